// File: rtl/ex_muldiv.sv
`default_nettype none
// ============================================================================
// Module   : ex_muldiv
// Brief    : Iterative MIPS32 multiply / divide / multiply-accumulate unit that
//            produces HI/LO one bit per cycle and can be annulled in flight.
// Revision : 1.0 - initial release
// ============================================================================
module ex_muldiv #(
    parameter int DATA_W = 32,
    parameter int CNT_W  = $clog2(DATA_W) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start_i,
    input  logic [2:0]        op_i,
    input  logic [DATA_W-1:0] opdata1_i,
    input  logic [DATA_W-1:0] opdata2_i,
    input  logic [DATA_W-1:0] hi_i,
    input  logic [DATA_W-1:0] lo_i,
    input  logic              annul_i,
    output logic              busy_o,
    output logic              ready_o,
    output logic              whilo_o,
    output logic [DATA_W-1:0] hi_o,
    output logic [DATA_W-1:0] lo_o,
    output logic              div_zero_o
);

    localparam int               c_W2   = 2 * DATA_W;
    localparam logic [1:0]       c_IDLE = 2'd0;
    localparam logic [1:0]       c_CALC = 2'd1;
    localparam logic [1:0]       c_DONE = 2'd2;
    localparam logic [CNT_W-1:0] c_LAST = CNT_W'(DATA_W - 1);

    logic [1:0]        r_state;
    logic [1:0]        w_state_nxt;
    logic [2:0]        r_op;
    logic [CNT_W-1:0]  r_cnt;
    logic [c_W2-1:0]   r_acc;
    logic [c_W2-1:0]   r_a;
    logic [c_W2-1:0]   r_hilo_in;
    logic [DATA_W-1:0] r_b;
    logic              r_neg_res;
    logic              r_neg_rem;

    // ------------------------------------------------------------------
    // Issue-side decode
    // ------------------------------------------------------------------
    logic              w_in_signed;
    logic              w_in_div;
    logic              w_accept;
    logic              w_div_zero;
    logic [DATA_W-1:0] w_mag1;
    logic [DATA_W-1:0] w_mag2;

    assign w_in_signed = ~op_i[0];
    assign w_in_div    = (op_i[2:1] == 2'b01);
    assign w_accept    = (r_state == c_IDLE) && start_i && !annul_i;
    assign w_div_zero  = w_in_div && (opdata2_i == '0);
    assign w_mag1      = (w_in_signed && opdata1_i[DATA_W-1]) ? -opdata1_i : opdata1_i;
    assign w_mag2      = (w_in_signed && opdata2_i[DATA_W-1]) ? -opdata2_i : opdata2_i;

    // ------------------------------------------------------------------
    // One iteration step. Divide keeps {remainder, dividend/quotient} in
    // r_acc with the divisor in r_a; multiply accumulates r_a (shifted
    // multiplicand) into r_acc under the LSB of r_b.
    // ------------------------------------------------------------------
    logic              w_is_div;
    logic [DATA_W:0]   w_rem_sh;
    logic [DATA_W:0]   w_trial;
    logic [c_W2-1:0]   w_div_step;
    logic [c_W2-1:0]   w_mul_step;
    logic [c_W2-1:0]   w_step;

    assign w_is_div   = (r_op[2:1] == 2'b01);
    assign w_rem_sh   = {r_acc[c_W2-1:DATA_W], r_acc[DATA_W-1]};
    assign w_trial    = w_rem_sh - {1'b0, r_a[DATA_W-1:0]};
    assign w_div_step = w_trial[DATA_W]
                      ? {w_rem_sh[DATA_W-1:0], r_acc[DATA_W-2:0], 1'b0}
                      : {w_trial[DATA_W-1:0],  r_acc[DATA_W-2:0], 1'b1};
    assign w_mul_step = r_acc + (r_b[0] ? r_a : '0);
    assign w_step     = w_is_div ? w_div_step : w_mul_step;

    // Sign fix-up and HI/LO accumulation applied to the last iteration result.
    logic [DATA_W-1:0] w_quot;
    logic [DATA_W-1:0] w_rem;
    logic [c_W2-1:0]   w_prod;
    logic [c_W2-1:0]   w_final;

    always_comb begin
        w_quot = r_neg_res ? -w_step[DATA_W-1:0] : w_step[DATA_W-1:0];
        w_rem  = r_neg_rem ? -w_step[c_W2-1:DATA_W] : w_step[c_W2-1:DATA_W];
        w_prod = r_neg_res ? -w_step : w_step;
        case (r_op[2:1])
            2'b01:   w_final = {w_rem, w_quot};
            2'b10:   w_final = r_hilo_in + w_prod;
            2'b11:   w_final = r_hilo_in - w_prod;
            default: w_final = w_prod;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // FSM: next state
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            c_IDLE: begin
                if (w_accept) begin
                    w_state_nxt = w_div_zero ? c_DONE : c_CALC;
                end
            end
            c_CALC: begin
                if (annul_i) begin
                    w_state_nxt = c_IDLE;
                end else if (r_cnt == c_LAST) begin
                    w_state_nxt = c_DONE;
                end
            end
            c_DONE:  w_state_nxt = c_IDLE;
            default: w_state_nxt = c_IDLE;
        endcase
    end

    // FSM: outputs
    always_comb begin
        busy_o  = (r_state == c_CALC) || (r_state == c_DONE);
        ready_o = (r_state == c_DONE);
        whilo_o = (r_state == c_DONE);
    end

    // ------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_op       <= '0;
            r_cnt      <= '0;
            r_acc      <= '0;
            r_a        <= '0;
            r_b        <= '0;
            r_hilo_in  <= '0;
            r_neg_res  <= 1'b0;
            r_neg_rem  <= 1'b0;
            hi_o       <= '0;
            lo_o       <= '0;
            div_zero_o <= 1'b0;
        end else if (w_accept) begin
            r_op      <= op_i;
            r_cnt     <= '0;
            r_hilo_in <= {hi_i, lo_i};
            r_neg_res <= w_in_signed && (opdata1_i[DATA_W-1] ^ opdata2_i[DATA_W-1]);
            r_neg_rem <= w_in_signed && opdata1_i[DATA_W-1];
            r_b       <= w_mag2;
            if (w_in_div) begin
                r_acc <= {{DATA_W{1'b0}}, w_mag1};
                r_a   <= {{DATA_W{1'b0}}, w_mag2};
            end else begin
                r_acc <= '0;
                r_a   <= {{DATA_W{1'b0}}, w_mag1};
            end
            // Zero divisor completes straight away without iterating.
            if (w_div_zero) begin
                hi_o       <= '0;
                lo_o       <= '0;
                div_zero_o <= 1'b1;
            end
        end else if ((r_state == c_CALC) && !annul_i) begin
            r_acc <= w_step;
            r_cnt <= r_cnt + CNT_W'(1);
            if (!w_is_div) begin
                r_a <= r_a << 1;
                r_b <= r_b >> 1;
            end
            if (r_cnt == c_LAST) begin
                hi_o       <= w_final[c_W2-1:DATA_W];
                lo_o       <= w_final[DATA_W-1:0];
                div_zero_o <= 1'b0;
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_ex_muldiv.sv
`default_nettype none
// Bench for ex_muldiv: a 32-bit and an 8-bit instance share stimulus and are
// checked every cycle against an arithmetic model with a latency counter.
module tb_ex_muldiv;

    logic        clk;
    logic        rst;
    logic        start;
    logic        annul;
    logic [2:0]  op_sel;
    logic [31:0] op1, op2, hi_in, lo_in;

    logic        busy32, ready32, whilo32, dz32;
    logic [31:0] hi32, lo32;
    logic        busy8, ready8, whilo8, dz8;
    logic [7:0]  hi8, lo8;

    logic        dut_busy  [2];
    logic        dut_ready [2];
    logic        dut_whilo [2];
    logic        dut_dz    [2];
    logic [31:0] dut_hi    [2];
    logic [31:0] dut_lo    [2];

    int n_cmp = 0;
    int n_bad = 0;

    ex_muldiv #(.DATA_W(32)) u_dut32 (
        .clk(clk), .rst(rst), .start_i(start), .op_i(op_sel),
        .opdata1_i(op1), .opdata2_i(op2), .hi_i(hi_in), .lo_i(lo_in),
        .annul_i(annul), .busy_o(busy32), .ready_o(ready32), .whilo_o(whilo32),
        .hi_o(hi32), .lo_o(lo32), .div_zero_o(dz32)
    );

    ex_muldiv #(.DATA_W(8)) u_dut8 (
        .clk(clk), .rst(rst), .start_i(start), .op_i(op_sel),
        .opdata1_i(op1[7:0]), .opdata2_i(op2[7:0]), .hi_i(hi_in[7:0]), .lo_i(lo_in[7:0]),
        .annul_i(annul), .busy_o(busy8), .ready_o(ready8), .whilo_o(whilo8),
        .hi_o(hi8), .lo_o(lo8), .div_zero_o(dz8)
    );

    assign dut_busy[0]  = busy32;
    assign dut_ready[0] = ready32;
    assign dut_whilo[0] = whilo32;
    assign dut_dz[0]    = dz32;
    assign dut_hi[0]    = hi32;
    assign dut_lo[0]    = lo32;
    assign dut_busy[1]  = busy8;
    assign dut_ready[1] = ready8;
    assign dut_whilo[1] = whilo8;
    assign dut_dz[1]    = dz8;
    assign dut_hi[1]    = {24'h0, hi8};
    assign dut_lo[1]    = {24'h0, lo8};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Result of one operation at width w, from plain integer arithmetic.
    // Returns {div_zero, hi[31:0], lo[31:0]}.
    function automatic logic [64:0] model_res(input int w, input logic [2:0] op,
                                              input logic [31:0] a, input logic [31:0] b,
                                              input logic [31:0] h, input logic [31:0] l);
        logic [63:0] mask, mask2, ua, ub, acc, prod, res;
        longint      sa, sb, q, r;
        logic        dz;
        mask  = (64'd1 << w) - 64'd1;
        mask2 = (w == 32) ? 64'hFFFF_FFFF_FFFF_FFFF : ((64'd1 << (2 * w)) - 64'd1);
        ua    = {32'h0, a} & mask;
        ub    = {32'h0, b} & mask;
        sa    = ua[w-1] ? $signed(ua - (64'd1 << w)) : $signed(ua);
        sb    = ub[w-1] ? $signed(ub - (64'd1 << w)) : $signed(ub);
        acc   = ((({32'h0, h} & mask) << w) | ({32'h0, l} & mask));
        dz    = 1'b0;
        res   = 64'h0;
        if (op[2:1] == 2'b01) begin
            if (ub == 64'h0) begin
                dz = 1'b1;
            end else if (op[0]) begin
                res = ((ua % ub) << w) | (ua / ub);
            end else begin
                q   = sa / sb;
                r   = sa % sb;
                res = (((64'(r)) & mask) << w) | ((64'(q)) & mask);
            end
        end else begin
            prod = op[0] ? (ua * ub) : 64'(sa * sb);
            case (op[2:1])
                2'b10:   res = acc + prod;
                2'b11:   res = acc - prod;
                default: res = prod;
            endcase
        end
        res = res & mask2;
        model_res = {dz, 32'((res >> w) & mask), 32'(res & mask)};
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_model
        localparam int W = (g == 0) ? 32 : 8;
        logic        m_pend, m_done;
        int          m_rem;
        logic [64:0] e_res, p_res, w_res;

        assign w_res = model_res(W, op_sel, op1, op2, hi_in, lo_in);

        always @(posedge clk or negedge rst) begin
            if (!rst) begin
                m_pend <= 1'b0;
                m_done <= 1'b0;
                m_rem  <= 0;
                e_res  <= '0;
                p_res  <= '0;
            end else if (m_done) begin
                m_done <= 1'b0;
            end else if (m_pend) begin
                if (annul) begin
                    m_pend <= 1'b0;
                end else if (m_rem == 1) begin
                    m_pend <= 1'b0;
                    m_done <= 1'b1;
                    e_res  <= p_res;
                end else begin
                    m_rem <= m_rem - 1;
                end
            end else if (start && !annul) begin
                if (w_res[64]) begin
                    m_done <= 1'b1;
                    e_res  <= w_res;
                end else begin
                    m_pend <= 1'b1;
                    m_rem  <= W;
                    p_res  <= w_res;
                end
            end
        end

        always @(negedge clk) begin
            chk($sformatf("w%0d_busy", W),  64'(dut_busy[g]),  64'(m_pend | m_done));
            chk($sformatf("w%0d_ready", W), 64'(dut_ready[g]), 64'(m_done));
            chk($sformatf("w%0d_whilo", W), 64'(dut_whilo[g]), 64'(m_done));
            chk($sformatf("w%0d_dz", W),    64'(dut_dz[g]),    64'(e_res[64]));
            chk($sformatf("w%0d_hi", W),    64'(dut_hi[g]),    64'(e_res[63:32]));
            chk($sformatf("w%0d_lo", W),    64'(dut_lo[g]),    64'(e_res[31:0]));
        end
    end

    task automatic drive(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] h, input logic [31:0] l);
        op_sel = op; op1 = a; op2 = b; hi_in = h; lo_in = l; start = 1'b1;
        @(negedge clk);
        start  = 1'b0;
        op_sel = 3'($urandom);
        op1    = $urandom;
        op2    = $urandom;
        hi_in  = $urandom;
        lo_in  = $urandom;
    endtask

    // Entered in cycle 1; returns in the cycle the 32-bit unit shows ready.
    task automatic wait_ready(output int n, output int n8);
        n  = 1;
        n8 = 0;
        while (!ready32 && n < 200) begin
            if (ready8 && n8 == 0) n8 = n;
            @(negedge clk);
            n++;
        end
        if (ready8 && n8 == 0) n8 = n;
        chk("ready_seen", 64'(ready32), 64'd1);
    endtask

    task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [31:0] h, input logic [31:0] l,
                         output int n, output int n8);
        @(negedge clk);
        drive(op, a, b, h, l);
        wait_ready(n, n8);
    endtask

    task automatic wait_idle();
        int n;
        n = 0;
        while ((busy32 || busy8) && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk("idle_reached", 64'(busy32 | busy8), 64'd0);
    endtask

    function automatic logic [31:0] pick();
        case ($urandom_range(0, 3))
            0: return $urandom;
            1: return 32'($urandom_range(0, 40)) - 32'd20;
            2: begin
                case ($urandom_range(0, 5))
                    0:       return 32'h0000_0000;
                    1:       return 32'h0000_0001;
                    2:       return 32'hFFFF_FFFF;
                    3:       return 32'h8000_0000;
                    4:       return 32'h7FFF_FFFF;
                    default: return 32'h0000_0080;
                endcase
            end
            default: return $urandom & 32'hFFFF_FF00;
        endcase
    endfunction

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, n8, cnt;
        rst = 1'b1; start = 1'b0; annul = 1'b0; op_sel = 3'd0;
        op1 = 32'h0; op2 = 32'h0; hi_in = 32'h0; lo_in = 32'h0;
        #1 rst = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_busy", 64'(busy32), 64'd0);
        chk("reset_hi", 64'(hi32), 64'd0);
        chk("reset_dz", 64'(dz32), 64'd0);
        #2 rst = 1'b1;

        do_op(3'b000, 32'hFFFF_FFFE, 32'h0000_0003, 32'h0, 32'h0, n, n8);
        chk("mult_latency", 64'(n), 64'd33);
        chk("mult_latency_w8", 64'(n8), 64'd9);
        chk("mult_hi", 64'(hi32), 64'hFFFF_FFFF);
        chk("mult_lo", 64'(lo32), 64'hFFFF_FFFA);
        chk("mult_w8_hi", 64'(hi8), 64'hFF);
        chk("mult_w8_lo", 64'(lo8), 64'hFA);
        chk("mult_whilo", 64'(whilo32), 64'd1);

        do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, n, n8);
        chk("multu_hi", 64'(hi32), 64'hFFFF_FFFE);
        chk("multu_lo", 64'(lo32), 64'h0000_0001);

        do_op(3'b010, 32'hFFFF_FFF9, 32'h2, 32'h0, 32'h0, n, n8);
        chk("div_neg_lo", 64'(lo32), 64'hFFFF_FFFD);
        chk("div_neg_hi", 64'(hi32), 64'hFFFF_FFFF);
        do_op(3'b011, 32'h7, 32'h2, 32'h0, 32'h0, n, n8);
        chk("divu_lo", 64'(lo32), 64'h3);
        chk("divu_hi", 64'(hi32), 64'h1);
        do_op(3'b010, 32'h7, 32'hFFFF_FFFE, 32'h0, 32'h0, n, n8);
        chk("div_negd_lo", 64'(lo32), 64'hFFFF_FFFD);
        chk("div_negd_hi", 64'(hi32), 64'h1);

        do_op(3'b010, 32'h5, 32'h0, 32'h0, 32'h0, n, n8);
        chk("divz_latency", 64'(n), 64'd1);
        chk("divz_latency_w8", 64'(n8), 64'd1);
        chk("divz_flag", 64'(dz32), 64'd1);
        chk("divz_hi", 64'(hi32), 64'h0);
        chk("divz_lo", 64'(lo32), 64'h0);
        @(negedge clk);
        chk("divz_idle_c2", 64'(busy32), 64'd0);
        do_op(3'b000, 32'h3, 32'h3, 32'h0, 32'h0, n, n8);
        chk("divz_cleared", 64'(dz32), 64'd0);
        chk("mult3x3_lo", 64'(lo32), 64'h9);

        do_op(3'b101, 32'h1, 32'h1, 32'h0, 32'hFFFF_FFFF, n, n8);
        chk("maddu_hi", 64'(hi32), 64'h1);
        chk("maddu_lo", 64'(lo32), 64'h0);
        do_op(3'b110, 32'h1, 32'h1, 32'h0, 32'h0, n, n8);
        chk("msub_hi", 64'(hi32), 64'hFFFF_FFFF);
        chk("msub_lo", 64'(lo32), 64'hFFFF_FFFF);
        do_op(3'b100, 32'hFFFF_FFFD, 32'h2, 32'h0, 32'd10, n, n8);
        chk("madd_lo", 64'(lo32), 64'h4);
        chk("madd_hi", 64'(hi32), 64'h0);

        // Annul a DIV in cycle 10, then start a new op in cycle 11.
        @(negedge clk);
        drive(3'b010, 32'd100, 32'd7, 32'h0, 32'h0);
        repeat (9) @(negedge clk);
        annul = 1'b1;
        @(negedge clk);
        annul = 1'b0;
        chk("annul_busy", 64'(busy32), 64'd0);
        chk("annul_hi_kept", 64'(hi32), 64'h0);
        chk("annul_lo_kept", 64'(lo32), 64'h4);
        drive(3'b011, 32'd100, 32'd7, 32'h0, 32'h0);
        wait_ready(n, n8);
        chk("after_annul_latency", 64'(n), 64'd33);
        chk("after_annul_lo", 64'(lo32), 64'd14);
        chk("after_annul_hi", 64'(hi32), 64'd2);

        // A start pulse while busy must not queue a second operation.
        @(negedge clk);
        drive(3'b000, 32'd7, 32'd6, 32'h0, 32'h0);
        repeat (4) @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cnt = 0;
        for (int i = 0; i < 40; i++) begin
            if (ready32) cnt++;
            @(negedge clk);
        end
        chk("spurious_start_ready_count", 64'(cnt), 64'd1);
        chk("spurious_start_lo", 64'(lo32), 64'd42);

        // Asynchronous reset in the middle of cycle 20 of a MULT.
        @(negedge clk);
        drive(3'b000, 32'h0001_2345, 32'h0000_0777, 32'h0, 32'h0);
        repeat (19) @(negedge clk);
        #2 rst = 1'b0;
        #1;
        chk("async_rst_busy", 64'(busy32), 64'd0);
        chk("async_rst_ready", 64'(ready32), 64'd0);
        chk("async_rst_hi", 64'(hi32), 64'd0);
        chk("async_rst_lo", 64'(lo32), 64'd0);
        chk("async_rst_busy8", 64'(busy8), 64'd0);
        @(negedge clk);
        @(negedge clk);
        #2 rst = 1'b1;
        do_op(3'b000, 32'd5, 32'd6, 32'h0, 32'h0, n, n8);
        chk("post_rst_latency", 64'(n), 64'd33);
        chk("post_rst_lo", 64'(lo32), 64'd30);

        do_op(3'b010, 32'h80, 32'hFF, 32'h0, 32'h0, n, n8);
        chk("w8_div_latency", 64'(n8), 64'd9);
        chk("w8_div_lo", 64'(lo8), 64'h80);
        chk("w8_div_hi", 64'(hi8), 64'h00);
        chk("w32_div_128_255_hi", 64'(hi32), 64'h80);

        for (int i = 0; i < 40; i++) begin
            logic [2:0]  op;
            logic [31:0] a, b;
            int          act, k;
            op  = 3'($urandom_range(0, 7));
            a   = pick();
            b   = pick();
            act = $urandom_range(0, 3);
            @(negedge clk);
            if (act == 3) begin
                op_sel = op; op1 = a; op2 = b; start = 1'b1; annul = 1'b1;
                @(negedge clk);
                start = 1'b0; annul = 1'b0;
            end else begin
                drive(op, a, b, $urandom, $urandom);
                if (act == 1) begin
                    k = $urandom_range(1, 34);
                    repeat (k - 1) @(negedge clk);
                    annul = 1'b1;
                    @(negedge clk);
                    annul = 1'b0;
                end else if (act == 2) begin
                    k = $urandom_range(1, 33);
                    repeat (k - 1) @(negedge clk);
                    start = 1'b1;
                    @(negedge clk);
                    start = 1'b0;
                end
            end
            wait_idle();
        end

        repeat (2) @(negedge clk);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
`default_nettype wire
